// File: rtl/control_pipe_pkg.sv
// rtl/control_pipe_pkg.sv - control word layout, opcode encodings and bubble constant
package control_pipe_pkg;

    localparam int CTRL_W = 8;
    localparam int REG_W  = 5;

    localparam int RW_B   = 7;
    localparam int M2R_B  = 6;
    localparam int MR_B   = 5;
    localparam int MW_B   = 4;
    localparam int ASRC_B = 3;
    localparam int AOP_HI = 2;
    localparam int AOP_LO = 1;
    localparam int RDST_B = 0;

    localparam logic [CTRL_W-1:0] CTRL_RTYPE = 8'h81;
    localparam logic [CTRL_W-1:0] CTRL_ORI   = 8'h8A;
    localparam logic [CTRL_W-1:0] CTRL_ADDI  = 8'h8C;
    localparam logic [CTRL_W-1:0] CTRL_LW    = 8'hEC;
    localparam logic [CTRL_W-1:0] CTRL_SW    = 8'h1C;
    localparam logic [CTRL_W-1:0] CTRL_BEQ   = 8'h0C;
    localparam logic [CTRL_W-1:0] CTRL_J     = 8'h00;
    localparam logic [CTRL_W-1:0] BUBBLE     = 8'h00;

endpackage

// File: rtl/control_pipe_hazard_detect.sv
// rtl/control_pipe_hazard_detect.sv - load-use hazard detection with flush override
module hazard_detect
    import control_pipe_pkg::*;
(
    input  logic             idex_mem_read,
    input  logic [REG_W-1:0] idex_wreg,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             flush,
    output logic             haz,
    output logic             stall
);

    // $0 is hardwired, so a load targeting it never creates a real dependency
    assign haz = idex_mem_read && (idex_wreg != '0) &&
                 ((idex_wreg == rs) || (idex_wreg == rt));

    // A wrong-path instruction is discarded rather than held
    assign stall = haz && !flush;

endmodule

// File: rtl/control_pipe.sv
// rtl/control_pipe.sv - ID/EX, EX/MEM, MEM/WB control registers with load-use stall and flush
module control_pipe
    import control_pipe_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [REG_W-1:0]  rs_i,
    input  logic [REG_W-1:0]  rt_i,
    input  logic [REG_W-1:0]  rd_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              ex_alusrc_o,
    output logic [1:0]        ex_aluop_o,
    output logic              ex_regdst_o,
    output logic [REG_W-1:0]  ex_wreg_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic              mem_regwrite_o,
    output logic [REG_W-1:0]  mem_wreg_o,
    output logic              wb_regwrite_o,
    output logic              wb_memtoreg_o,
    output logic [REG_W-1:0]  wb_wreg_o
);

    logic [CTRL_W-1:0] idex_ctrl;
    logic [REG_W-1:0]  idex_wreg;

    logic              exmem_regwrite;
    logic              exmem_memtoreg;
    logic              exmem_read;
    logic              exmem_write;
    logic [REG_W-1:0]  exmem_wreg;

    logic              memwb_regwrite;
    logic              memwb_memtoreg;
    logic [REG_W-1:0]  memwb_wreg;

    logic              haz;
    logic [REG_W-1:0]  id_wreg;

    assign id_wreg = ctrl_i[RDST_B] ? rd_i : rt_i;

    hazard_detect u_hazard_detect (
        .idex_mem_read (idex_ctrl[MR_B]),
        .idex_wreg     (idex_wreg),
        .rs            (rs_i),
        .rt            (rt_i),
        .flush         (flush_i),
        .haz           (haz),
        .stall         (stall_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idex_ctrl <= BUBBLE;
            idex_wreg <= '0;
        end else if (haz || flush_i) begin
            idex_ctrl <= BUBBLE;
            idex_wreg <= '0;
        end else begin
            idex_ctrl <= ctrl_i;
            idex_wreg <= id_wreg;
        end
    end

    // Downstream stages never freeze; only the fields later stages consume are carried
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            exmem_regwrite <= 1'b0;
            exmem_memtoreg <= 1'b0;
            exmem_read     <= 1'b0;
            exmem_write    <= 1'b0;
            exmem_wreg     <= '0;
            memwb_regwrite <= 1'b0;
            memwb_memtoreg <= 1'b0;
            memwb_wreg     <= '0;
        end else begin
            exmem_regwrite <= idex_ctrl[RW_B];
            exmem_memtoreg <= idex_ctrl[M2R_B];
            exmem_read     <= idex_ctrl[MR_B];
            exmem_write    <= idex_ctrl[MW_B];
            exmem_wreg     <= idex_wreg;
            memwb_regwrite <= exmem_regwrite;
            memwb_memtoreg <= exmem_memtoreg;
            memwb_wreg     <= exmem_wreg;
        end
    end

    assign ex_alusrc_o    = idex_ctrl[ASRC_B];
    assign ex_aluop_o     = idex_ctrl[AOP_HI:AOP_LO];
    assign ex_regdst_o    = idex_ctrl[RDST_B];
    assign ex_wreg_o      = idex_wreg;
    assign mem_read_o     = exmem_read;
    assign mem_write_o    = exmem_write;
    assign mem_regwrite_o = exmem_regwrite;
    assign mem_wreg_o     = exmem_wreg;
    assign wb_regwrite_o  = memwb_regwrite;
    assign wb_memtoreg_o  = memwb_memtoreg;
    assign wb_wreg_o      = memwb_wreg;

endmodule

// File: tb/tb_control_pipe.sv
// tb/tb_control_pipe.sv - directed self-checking bench for control_pipe
module tb_control_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ctrl;
    logic [4:0] rs, rt, rd;
    logic       flush;
    logic       stall;
    logic       ex_alusrc;
    logic [1:0] ex_aluop;
    logic       ex_regdst;
    logic [4:0] ex_wreg;
    logic       mem_read, mem_write, mem_regwrite;
    logic [4:0] mem_wreg;
    logic       wb_regwrite, wb_memtoreg;
    logic [4:0] wb_wreg;

    int n_assert = 0;
    int n_fail   = 0;

    control_pipe dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ctrl_i         (ctrl),
        .rs_i           (rs),
        .rt_i           (rt),
        .rd_i           (rd),
        .flush_i        (flush),
        .stall_o        (stall),
        .ex_alusrc_o    (ex_alusrc),
        .ex_aluop_o     (ex_aluop),
        .ex_regdst_o    (ex_regdst),
        .ex_wreg_o      (ex_wreg),
        .mem_read_o     (mem_read),
        .mem_write_o    (mem_write),
        .mem_regwrite_o (mem_regwrite),
        .mem_wreg_o     (mem_wreg),
        .wb_regwrite_o  (wb_regwrite),
        .wb_memtoreg_o  (wb_memtoreg),
        .wb_wreg_o      (wb_wreg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] c, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic f);
        ctrl  = c;
        rs    = s;
        rt    = t;
        rd    = d;
        flush = f;
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_all"}, {stall, ex_alusrc, ex_aluop, ex_regdst, mem_read, mem_write,
                            mem_regwrite}, 8'h00);
        chk({tag, "_wregs"}, {3'b0, ex_wreg} | {3'b0, mem_wreg} | {3'b0, wb_wreg}, 8'h00);
        chk({tag, "_wb"}, {6'b0, wb_regwrite, wb_memtoreg}, 8'h00);
    endtask

    initial begin
        rst = 1'b1;
        drive(8'h81, 5'd1, 5'd2, 5'd3, 1'b0);
        chk_all_zero("reset_async");
        edge_step();
        chk_all_zero("reset_edge1");
        edge_step();
        chk_all_zero("reset_edge2");
        rst = 1'b0;

        // Flow: R-type rd=3, addi rt=4, sw, then j
        edge_step();
        chk("flow_ex_regdst", {7'b0, ex_regdst}, 8'h01);
        chk("flow_ex_wreg_r", {3'b0, ex_wreg}, 8'h03);
        drive(8'h8C, 5'd1, 5'd4, 5'd0, 1'b0);
        edge_step();
        chk("flow_ex_wreg_addi", {3'b0, ex_wreg}, 8'h04);
        chk("flow_ex_alu_addi", {5'b0, ex_alusrc, ex_aluop}, 8'h06);
        chk("flow_mem_r", {2'b0, mem_regwrite, mem_wreg}, 8'h23);
        drive(8'h1C, 5'd1, 5'd6, 5'd0, 1'b0);
        edge_step();
        chk("flow_wb_r", {2'b0, wb_regwrite, wb_wreg}, 8'h23);
        chk("flow_mem_addi", {2'b0, mem_regwrite, mem_wreg}, 8'h24);
        drive(8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        edge_step();
        chk("flow_wb_addi", {2'b0, wb_regwrite, wb_wreg}, 8'h24);
        chk("flow_mem_sw", {6'b0, mem_write, mem_regwrite}, 8'h02);
        edge_step();
        chk("flow_wb_sw", {7'b0, wb_regwrite}, 8'h00);
        chk("flow_mem_j", {7'b0, mem_write}, 8'h00);

        // Load-use: lw rt=5 then R-type using rs=5
        drive(8'hEC, 5'd1, 5'd5, 5'd0, 1'b0);
        edge_step();
        drive(8'h81, 5'd5, 5'd2, 5'd7, 1'b0);
        chk("lu_stall", {7'b0, stall}, 8'h01);
        edge_step();
        chk("lu_bubble_ex", {3'b0, ex_alusrc, ex_aluop, ex_regdst}, 8'h00);
        chk("lu_bubble_wreg", {3'b0, ex_wreg}, 8'h00);
        chk("lu_mem_lw", {2'b0, mem_read, mem_wreg}, 8'h25);
        chk("lu_stall_one_cycle", {7'b0, stall}, 8'h00);
        edge_step();
        chk("lu_rtype_enters", {2'b0, ex_regdst, ex_wreg}, 8'h27);
        chk("lu_wb_lw", {1'b0, wb_memtoreg, wb_regwrite, wb_wreg}, 8'h65);
        drive(8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        edge_step();
        chk("lu_wb_bubble", {6'b0, wb_memtoreg, wb_regwrite}, 8'h00);
        edge_step();
        chk("lu_wb_rtype", {1'b0, wb_memtoreg, wb_regwrite, wb_wreg}, 8'h27);

        // No false stall: $0 destination, and unrelated sources
        drive(8'hEC, 5'd1, 5'd0, 5'd0, 1'b0);
        edge_step();
        drive(8'h81, 5'd0, 5'd0, 5'd3, 1'b0);
        chk("nf_zero_reg", {7'b0, stall}, 8'h00);
        chk("nf_zero_ex", {3'b0, ex_wreg}, 8'h00);
        edge_step();
        drive(8'hEC, 5'd1, 5'd5, 5'd0, 1'b0);
        edge_step();
        drive(8'h1C, 5'd6, 5'd7, 5'd0, 1'b0);
        chk("nf_unrelated", {7'b0, stall}, 8'h00);
        edge_step();
        chk("nf_sw_enters", {3'b0, ex_wreg}, 8'h07);

        // Flush with a simultaneous hazard
        drive(8'hEC, 5'd1, 5'd5, 5'd0, 1'b0);
        edge_step();
        drive(8'h8C, 5'd5, 5'd5, 5'd0, 1'b1);
        chk("fl_stall", {7'b0, stall}, 8'h00);
        edge_step();
        chk("fl_bubble", {3'b0, ex_alusrc, ex_aluop, ex_regdst}, 8'h00);
        chk("fl_bubble_wreg", {3'b0, ex_wreg}, 8'h00);
        drive(8'h8C, 5'd1, 5'd4, 5'd0, 1'b0);
        chk("fl_next_no_stall", {7'b0, stall}, 8'h00);
        edge_step();
        chk("fl_next_enters", {4'b0, ex_alusrc, ex_wreg[2:0]}, 8'h0C);

        // Mid-run asynchronous reset while lw sits in EX/MEM
        drive(8'hEC, 5'd1, 5'd5, 5'd0, 1'b0);
        edge_step();
        drive(8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        edge_step();
        chk("mr_lw_in_mem", {2'b0, mem_read, mem_wreg}, 8'h25);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_async_mem_read", {7'b0, mem_read}, 8'h00);
        chk_all_zero("mr_async");
        #2;
        rst = 1'b0;
        edge_step();
        chk("mr_no_wb_pulse1", {6'b0, wb_regwrite, wb_memtoreg}, 8'h00);
        edge_step();
        chk("mr_no_wb_pulse2", {6'b0, wb_regwrite, wb_memtoreg}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/control_pipe.md
Name: control_pipe

Overview:
- Consumer end of the 8-bit control word produced by the ID-stage control decoder.
- Registers the word through the ID/EX, EX/MEM and MEM/WB pipeline boundaries and resolves the write-register number.
- Detects load-use hazards, asserts a stall and inserts bubbles; also accepts a branch/jump flush.
- Sits between the decoder and the EX/MEM/WB datapath muxes, register file write port, and PC/IF-ID enable logic.

Parameters:
- CTRL_W, 8, control word width.
- REG_W, 5, register-number width.

Ports:
- clk_i  in  1  clock; all registers sample on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- ctrl_i  in  CTRL_W  control word of the instruction in ID.
- rs_i  in  REG_W  rs field of the ID instruction.
- rt_i  in  REG_W  rt field of the ID instruction.
- rd_i  in  REG_W  rd field of the ID instruction.
- flush_i  in  1  branch/jump taken; the ID instruction is wrong-path.
- stall_o  out  1  combinational; hold PC and IF/ID this cycle.
- ex_alusrc_o  out  1  ID/EX ALUSrc.
- ex_aluop_o  out  2  ID/EX ALUOp.
- ex_regdst_o  out  1  ID/EX RegDst.
- ex_wreg_o  out  REG_W  ID/EX resolved write register.
- mem_read_o  out  1  EX/MEM MemRead.
- mem_write_o  out  1  EX/MEM MemWrite.
- mem_regwrite_o  out  1  EX/MEM RegWrite, for forwarding.
- mem_wreg_o  out  REG_W  EX/MEM write register.
- wb_regwrite_o  out  1  MEM/WB RegWrite.
- wb_memtoreg_o  out  1  MEM/WB MemtoReg.
- wb_wreg_o  out  REG_W  MEM/WB write register.

Behaviour:
- Control word layout:
  - bit7 RegWrite, bit6 MemtoReg, bit5 MemRead, bit4 MemWrite, bit3 ALUSrc, bits2:1 ALUOp, bit0 RegDst.
  - Encodings: R-type 8'h81, ori 8'h8A, addi 8'h8C, lw 8'hEC, sw 8'h1C, beq 8'h0C, j 8'h00.
- Write-register resolution in ID: wreg = RegDst ? rd_i : rt_i. It is stored in ID/EX and then propagated unchanged.
- Reset: every pipeline register clears to 0 asynchronously while rst_i is high. All outputs read 0, including stall_o, because ID/EX MemRead is 0.
- Latency:
  - ID/EX fields appear on ex_* one cycle after ctrl_i.
  - EX/MEM fields appear on mem_* two cycles after ctrl_i.
  - MEM/WB fields appear on wb_* three cycles after ctrl_i.
- Hazard condition: haz = idex_MemRead & (idex_wreg != 0) & ((idex_wreg == rs_i) | (idex_wreg == rt_i)).
- stall_o = haz & ~flush_i.
- ID/EX load each cycle:
  - If haz or flush_i: load the bubble (all control bits 0, wreg 0).
  - Otherwise: load {ctrl_i, wreg}.
- EX/MEM and MEM/WB always advance. Stall and flush never freeze or clear the downstream stages.
- A load-use stall lasts exactly one cycle. After the bubble, idex_MemRead = 0, so haz drops and the held instruction re-presents on the next cycle.
- flush_i and haz together: bubble inserted, stall_o = 0. The wrong-path instruction is discarded, not held.
- Register 0 never triggers a stall. An lw to $0 followed by a use of $0 gives stall_o = 0.
- EX/MEM and MEM/WB carry only the fields their stage and later stages need. Unused fields are dropped at each boundary.
- Reset asserted mid-operation: all in-flight control is lost and every stage reads as a bubble on the next observable edge. Release needs no synchronisation inside this block.

Decomposition:
- Shared package holds:
  - bit-index localparams for the control word (RW_B=7, M2R_B=6, MR_B=5, MW_B=4, ASRC_B=3, AOP_HI=2, AOP_LO=1, RDST_B=0);
  - the opcode encodings listed above;
  - the BUBBLE constant 8'h00.
- One natural sub-module, hazard_detect: combinational haz/stall_o from the ID/EX MemRead and wreg, rs_i, rt_i and flush_i.
- The pipeline registers stay in control_pipe.

Test Plan:
- Reset: assert rst_i with ctrl_i=8'h81 at the same time -> all outputs 0 throughout. After release, the R-type reaches ex_* on the next edge.
- Flow: R-type (8'h81, rd=3), then addi (8'h8C, rt=4), then sw (8'h1C) -> ex_wreg_o=3 then 4. wb_regwrite_o=1 at cycles 3 and 4 with wb_wreg_o=3 then 4. sw gives mem_write_o=1 and wb_regwrite_o=0.
- Load-use: lw (8'hEC, rt=5), then R-type with rs=5 -> stall_o=1 for exactly one cycle. The ex_* bubble is all 0. The R-type enters ID/EX the next cycle. wb_memtoreg_o=1 appears for the lw only.
- No false stall: lw rt=0, then a use with rs=0 -> stall_o=0. lw rt=5, then sw with rs=6, rt=7 -> stall_o=0.
- Flush plus hazard: lw rt=5 in ID/EX, ID rt_i=5, flush_i=1 -> stall_o=0 and the ID/EX bubble loads. The next instruction proceeds with no stall.
- Mid-run reset: pulse rst_i between edges while lw is in EX/MEM -> mem_read_o drops to 0 immediately, asynchronously. No wb_regwrite_o pulse follows.
